multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 61 ++++++
 rtl/multicycle_control_decode.sv | 61 ++++++
 rtl/multicycle_control.sv | 93 +++++++++
 tb/tb_multicycle_control.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// ALU/mux select codes and the bundled control-word type.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S0_FETCH   = 4'd0,
        S1_DECODE  = 4'd1,
        S2_MEMADR  = 4'd2,
        S3_MEMRD   = 4'd3,
        S4_MEMWB   = 4'd4,
        S5_MEMWR   = 4'd5,
        S6_EXEC    = 4'd6,
        S7_RTYPEWB = 4'd7,
        S8_BRANCH  = 4'd8,
        S9_JUMP    = 4'd9,
        S10_ADDIEX = 4'd10,
        S11_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Moore output decode: maps the current state to the datapath control word.
module control_decode
    import multicycle_control_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Per-state control word; anything not listed for a state stays 0.
    always_comb begin
        // NOTE: default every output before the case so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        ctrl = '0;
        case (state)
            S0_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S1_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
            S2_MEMADR, S10_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S3_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S4_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S5_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S6_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S7_RTYPEWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S8_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S9_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S11_ADDIWB: ctrl.reg_write = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: 4-bit Moore FSM plus opcode legality flag.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_gated;

    // State register; reset forces FETCH without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples its inputs from before the clock edge.
        if (rst) state_q <= S0_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic; opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d = S0_FETCH;
        case (state_q)
            S0_FETCH: state_d = S1_DECODE;
            S1_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S2_MEMADR;
                    OP_RTYPE:     state_d = S6_EXEC;
                    OP_BEQ:       state_d = S8_BRANCH;
                    OP_J:         state_d = S9_JUMP;
                    OP_ADDI:      state_d = S10_ADDIEX;
                    default:      state_d = S0_FETCH;
                endcase
            end
            S2_MEMADR: begin
                if (opcode == OP_LW)      state_d = S3_MEMRD;
                else if (opcode == OP_SW) state_d = S5_MEMWR;
                else                      state_d = S0_FETCH;
            end
            S3_MEMRD:   state_d = S4_MEMWB;
            S6_EXEC:    state_d = S7_RTYPEWB;
            S10_ADDIEX: state_d = S11_ADDIWB;
            default:    state_d = S0_FETCH;
        endcase
    end

    control_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // Hold every strobe low while reset is asserted, including FETCH's,
    // so an aborted instruction can never write memory or registers.
    always_comb begin
        ctrl_gated = rst ? '0 : ctrl;
    end

    assign pc_write      = ctrl_gated.pc_write;
    assign pc_write_cond = ctrl_gated.pc_write_cond;
    assign i_or_d        = ctrl_gated.i_or_d;
    assign mem_read      = ctrl_gated.mem_read;
    assign mem_write     = ctrl_gated.mem_write;
    assign ir_write      = ctrl_gated.ir_write;
    assign mem_to_reg    = ctrl_gated.mem_to_reg;
    assign reg_dst       = ctrl_gated.reg_dst;
    assign reg_write     = ctrl_gated.reg_write;
    assign alu_src_a     = ctrl_gated.alu_src_a;
    assign alu_src_b     = ctrl_gated.alu_src_b;
    assign alu_op        = ctrl_gated.alu_op;
    assign pc_source     = ctrl_gated.pc_source;

    assign illegal = !rst && (state_q == S1_DECODE) && !is_supported(opcode);
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequences, reset abort,
// illegal opcode and opcode noise outside the decode states.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal       (illegal),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Observed control word: pw,pwc,iord,mr | mw,irw,m2r,rd | rw,asa,asb | aop,ps
    wire [15:0] ctrl_obs = {pc_write, pc_write_cond, i_or_d, mem_read,
                            mem_write, ir_write, mem_to_reg, reg_dst,
                            reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    // Hand-derived expected control word for each state.
    function automatic logic [15:0] exp_ctrl(input logic [3:0] s);
        case (s)
            4'd0:    return 16'h9410;
            4'd1:    return 16'h0030;
            4'd2:    return 16'h0060;
            4'd3:    return 16'h3000;
            4'd4:    return 16'h0280;
            4'd5:    return 16'h2800;
            4'd6:    return 16'h0048;
            4'd7:    return 16'h0180;
            4'd8:    return 16'h4045;
            4'd9:    return 16'h8002;
            4'd10:   return 16'h0060;
            4'd11:   return 16'h0080;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; seq holds expected states, low nibble
    // first. Optionally scrambles opcode in every state but DECODE/MEMADR.
    task automatic run_instr(input string name, input logic [5:0] op,
                             input logic [23:0] seq, input int len,
                             input logic exp_ill, input logic toggle,
                             output int rw_cnt, output int mw_cnt);
        logic [3:0] es;
        logic [5:0] junk [3];
        junk[0] = 6'h2B; junk[1] = 6'h04; junk[2] = 6'h3F;
        rw_cnt = 0;
        mw_cnt = 0;
        opcode = toggle ? junk[0] : op;
        for (int i = 0; i < len; i++) begin
            es = seq[4*i +: 4];
            if (toggle) opcode = (es == 4'd1 || es == 4'd2) ? op : junk[i % 3];
            #0;
            total++;
            if (state !== es) begin
                bad++;
                $display("FAIL %s state[%0d]: got %0d want %0d", name, i, state, es);
            end
            total++;
            if (ctrl_obs !== exp_ctrl(es)) begin
                bad++;
                $display("FAIL %s ctrl[%0d]: got %h want %h", name, i, ctrl_obs, exp_ctrl(es));
            end
            total++;
            if (illegal !== (exp_ill && i == 1)) begin
                bad++;
                $display("FAIL %s illegal[%0d]: got %b want %b", name, i, illegal, exp_ill && i == 1);
            end
            if (reg_write === 1'b1) rw_cnt++;
            if (mem_write === 1'b1) mw_cnt++;
            if (i < len - 1) step();
        end
    endtask

    task automatic test_reset();
        opcode = 6'h3F;
        repeat (2) step();
        total++;
        if (state !== 4'd0 || ctrl_obs !== 16'h0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got state=%0d ctrl=%h ill=%b want 0/0000/0", state, ctrl_obs, illegal);
        end
        #3 rst = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || ctrl_obs !== 16'h9410) begin
            bad++;
            $display("FAIL reset_release: got state=%0d ctrl=%h want 0/9410", state, ctrl_obs);
        end
    endtask

    task automatic test_reset_mid_lw();
        int rw, mw;
        opcode = 6'h23;
        repeat (3) step();
        total++;
        if (state !== 4'd3) begin
            bad++;
            $display("FAIL mid_lw_reach_s3: got %0d want 3", state);
        end
        rst = 1'b1;
        #1;
        total++;
        if (state !== 4'd0 || ctrl_obs !== 16'h0) begin
            bad++;
            $display("FAIL async_reset: got state=%0d ctrl=%h want 0/0000", state, ctrl_obs);
        end
        step();
        total++;
        if (state !== 4'd0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: got state=%0d rw=%b mw=%b want 0/0/0", state, reg_write, mem_write);
        end
        #3 rst = 1'b0;
        #1;
        run_instr("lw", 6'h23, 24'h043210, 6, 1'b0, 1'b0, rw, mw);
        total++;
        if (rw !== 1 || mw !== 0) begin
            bad++;
            $display("FAIL lw_strobes: got rw=%0d mw=%0d want 1/0", rw, mw);
        end
    endtask

    task automatic test_sw();
        int rw, mw;
        run_instr("sw", 6'h2B, 24'h005210, 5, 1'b0, 1'b0, rw, mw);
        total++;
        if (rw !== 0 || mw !== 1) begin
            bad++;
            $display("FAIL sw_strobes: got rw=%0d mw=%0d want 0/1", rw, mw);
        end
    endtask

    task automatic test_rtype();
        int rw, mw;
        run_instr("rtype", 6'h00, 24'h007610, 5, 1'b0, 1'b0, rw, mw);
        total++;
        if (rw !== 1 || mw !== 0) begin
            bad++;
            $display("FAIL rtype_strobes: got rw=%0d mw=%0d want 1/0", rw, mw);
        end
    endtask

    task automatic test_back_to_back_branch_jump();
        int rw, mw;
        run_instr("beq", 6'h04, 24'h000810, 4, 1'b0, 1'b0, rw, mw);
        total++;
        if (rw !== 0 || mw !== 0) begin
            bad++;
            $display("FAIL beq_strobes: got rw=%0d mw=%0d want 0/0", rw, mw);
        end
        run_instr("j", 6'h02, 24'h000910, 4, 1'b0, 1'b0, rw, mw);
        total++;
        if (rw !== 0 || mw !== 0) begin
            bad++;
            $display("FAIL j_strobes: got rw=%0d mw=%0d want 0/0", rw, mw);
        end
    endtask

    task automatic test_illegal_then_addi();
        int rw, mw;
        run_instr("illegal", 6'h3F, 24'h000010, 3, 1'b1, 1'b0, rw, mw);
        total++;
        if (rw !== 0 || mw !== 0) begin
            bad++;
            $display("FAIL illegal_strobes: got rw=%0d mw=%0d want 0/0", rw, mw);
        end
        run_instr("addi", 6'h08, 24'h0BA10, 5, 1'b0, 1'b0, rw, mw);
        total++;
        if (rw !== 1 || mw !== 0) begin
            bad++;
            $display("FAIL addi_strobes: got rw=%0d mw=%0d want 1/0", rw, mw);
        end
    endtask

    task automatic test_opcode_noise();
        int rw, mw;
        run_instr("rtype_noise", 6'h00, 24'h007610, 5, 1'b0, 1'b1, rw, mw);
        total++;
        if (rw !== 1 || mw !== 0) begin
            bad++;
            $display("FAIL noise_strobes: got rw=%0d mw=%0d want 1/0", rw, mw);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        test_reset();
        test_reset_mid_lw();
        test_sw();
        test_rtype();
        test_back_to_back_branch_jump();
        test_illegal_then_addi();
        test_opcode_noise();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
